// File: rtl/qpmm_rr_arbiter.sv
// Round-robin front end that shares one pipelined Montgomery multiplier among NUM_REQ requesters.
// Results are routed back through a tag pipeline that runs in lockstep with the core latency.
module qpmm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 256,
    parameter int LATENCY = 40,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*W-1:0] req_a_i,
    input  logic [NUM_REQ*W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [W-1:0]         rsp_z_o,
    output logic                 mm_valid_o,
    output logic [W-1:0]         mm_a_o,
    output logic [W-1:0]         mm_b_o,
    input  logic                 mm_valid_i,
    input  logic [W-1:0]         mm_z_i,
    output logic                 busy_o,
    output logic                 err_o
);

    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic [ID_W-1:0]    mm_id;
    logic [LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]    tag_id [LATENCY];
    logic               tail_valid;
    logic [ID_W-1:0]    tail_id;
    logic               rsp_fire;
    logic               pipe_busy;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && !rst && req_valid_i[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign req_ready_o = grant;
    assign accept      = |grant;

    assign tail_valid = tag_valid[LATENCY-1];
    assign tail_id    = tag_id[LATENCY-1];
    assign rsp_fire   = mm_valid_i & tail_valid;

    // Stages 0..LATENCY-2 still hold an op on the next cycle after shifting.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_busy = pipe_busy | tag_valid[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            mm_valid_o  <= 1'b0;
            mm_a_o      <= '0;
            mm_b_o      <= '0;
            mm_id       <= '0;
            // NOTE: the tag array is cleared on reset so dropped ops can never produce a response.
            tag_valid   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id[i] <= '0;
            end
            rsp_valid_o <= '0;
            rsp_z_o     <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mm_valid_o <= accept;
            if (accept) begin
                ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                mm_a_o <= req_a_i[grant_id*W +: W];
                mm_b_o <= req_b_i[grant_id*W +: W];
                mm_id  <= grant_id;
            end

            // Stage 0 captures the op while it sits on the issue port, so the tail meets mm_valid_i.
            tag_valid[0] <= mm_valid_o;
            tag_id[0]    <= mm_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end

            if (rsp_fire) begin
                rsp_valid_o <= NUM_REQ'(1) << tail_id;
                rsp_z_o     <= mm_z_i;
            end else begin
                rsp_valid_o <= '0;
            end

            if (mm_valid_i != tail_valid) err_o <= 1'b1;

            busy_o <= accept | mm_valid_o | pipe_busy | rsp_fire;
        end
    end

endmodule
